command_issue_control: RTL and testbench
========================================

# command_issue_control

Issue stage that sits directly downstream of `restart_control` and the normal command arbiter, and directly upstream of the PSL command interface. It merges restart and flushed commands with normal compute-unit commands, allocates PSL tags, and enforces the PSL credit limit. It also feeds `restart_control` three things: the issued-command record, the issued tag, and the live credit count.

## Interface

Parameters:
- `CREDITS_TOTAL`, default from `CREDIT_PKG`: PSL credit pool size and reset credit count.
- `TAG_COUNT`, default 256: number of PSL tags; tags are 0..TAG_COUNT-1.
- `RESTART_FIFO_DEPTH`, default `CREDITS_TOTAL`: depth of the restart skid FIFO.

Ports:
- `clock`  in  1  single clock; everything is posedge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `enabled_in`  in  1  block enable, registered internally (1-cycle delay).
- `command_in`  in  `CommandBufferLine`  normal command; `.valid` qualifies it.
- `command_in_ready`  out  1  combinational accept for `command_in`.
- `restart_command_in`  in  `CommandBufferLine`  from `restart_control.restart_command_out`; has no backpressure.
- `restart_pending_in`  in  1  from `restart_control.restart_pending`.
- `response_in`  in  `ResponseInterface`  PSL response; uses `.valid` and `.tag`.
- `command_out`  out  `CommandBufferLine`  to PSL; `.cmd.tag` equals `command_tag_out`.
- `command_tag_out`  out  [0:7]  tag of `command_out`.
- `credits_out`  out  [0:7]  available credits, also driven to `restart_control.credits_in`.
- `restart_fifo_overflow`  out  1  sticky error flag.

## Operation

Enable:
- When the internal `enabled` is 0: no pop, no issue, `command_out.valid`=0, and credit/tag state holds.

Restart skid FIFO:
- Pushes `restart_command_in` whenever `restart_command_in.valid`=1, regardless of `enabled`.
- A push while full drops the entry and sets `restart_fifo_overflow`; the flag clears only on reset.

Tag pool:
- `TAG_COUNT`-bit busy vector plus a rolling pointer `tag_ptr`.
- `tag_free` = ~busy[tag_ptr].
- On issue: set busy[tag_ptr] and advance `tag_ptr` by 1 modulo `TAG_COUNT`, wrapping 255→0.
- If busy[tag_ptr]=1 and an issue is wanted: no issue that cycle, `tag_ptr` still advances (scan).
- On `response_in.valid`: clear busy[`response_in.tag`]. Clearing the current `tag_ptr` in the same cycle makes it free next cycle, not this cycle.

Credits (8-bit):
- Issue: −1. Valid response: +1. Both in the same cycle: unchanged.
- A response while credits = `CREDITS_TOTAL` holds the value (no wrap); decrement at 0 cannot occur because issue requires credits>0.

Arbitration, evaluated each enabled cycle; can_issue = credits>0 && tag_free:
1. Restart FIFO non-empty and can_issue: pop the head and issue it unchanged (its `abt` is already set upstream).
2. Otherwise, `command_in_ready` = ~`restart_pending_in` && restart FIFO empty && can_issue. When `command_in.valid` && `command_in_ready`, issue `command_in`.
3. Otherwise no issue; `command_out.valid`=0 next cycle.

Restart priority:
- While `restart_pending_in`=1, normal commands are never accepted; only FIFO content issues.

## Timing

Reset values:
- `command_out`=0, `command_tag_out`=0, `credits_out`=`CREDITS_TOTAL`, `restart_fifo_overflow`=0.
- busy vector all 0, `tag_ptr`=0, FIFO empty, `enabled`=0.

Latency and handshake:
- Issue decision in cycle N → `command_out.valid`=1 with tag at N+1; `credits_out` reflects the decrement at N+1.
- `command_out` is a 1-cycle pulse per command; back-to-back issue at one per cycle is supported.
- `command_in` is consumed on the edge where valid && ready; the upstream source pops on that same edge.
- Restart entry pushed at edge N is eligible for issue at cycle N+1, so earliest `command_out` is at N+2.
- `response_in` updates the busy vector and credits on the edge it is sampled; the freed credit is usable the next cycle.

Reset mid-operation (async assert):
- All outputs return to reset values immediately.
- FIFO content and outstanding tags are discarded, with no further issue.

## Test plan

- Reset, enable, 3 normal commands back-to-back → `command_out` at cycles 1/2/3 with tags 0,1,2; `credits_out` goes `CREDITS_TOTAL`−1, −2, −3.
- Issue `CREDITS_TOTAL` commands with no responses → `command_in_ready`=0 and credits=0. One response (tag 5) → ready=1 the next cycle and the issued command gets the next free `tag_ptr` tag.
- Simultaneous issue and response → `credits_out` unchanged. Response with credits already at `CREDITS_TOTAL` → stays at `CREDITS_TOTAL`.
- `restart_pending_in`=1, 2 restart pushes, `command_in.valid`=1 → both restart commands issue in order, `command_in_ready`=0 throughout. Deassert pending → the normal command issues.
- Tag 0 kept busy, `tag_ptr` wrapped to 0 after 256 issues → one stall cycle, then the command issues with tag 1.
- `RESTART_FIFO_DEPTH`+1 restart pushes while credits=0 → `restart_fifo_overflow`=1 and stays 1. Async `rstn` low mid-burst → `command_out.valid`=0 and credits=`CREDITS_TOTAL` immediately.

Source files
------------

// File: rtl/command_issue_control.sv
// rtl/command_issue_control.sv - PSL command issue stage: restart/normal merge, tag allocation, credit limit
package credit_pkg;
    localparam int CREDITS_TOTAL = 16;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [2:0]  abt;
        logic [7:0]  tag;
        logic [31:0] address;
    } command_t;

    typedef struct packed {
        logic     valid;
        command_t cmd;
    } command_buffer_line_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] tag;
        logic [7:0] response;
    } response_interface_t;
endpackage

module command_issue_control #(
    parameter int CREDITS_TOTAL      = credit_pkg::CREDITS_TOTAL,
    parameter int TAG_COUNT          = 256,
    parameter int RESTART_FIFO_DEPTH = CREDITS_TOTAL
) (
    input  logic                             clock,
    input  logic                             rstn,
    input  logic                             enabled_in,
    input  credit_pkg::command_buffer_line_t command_in,
    output logic                             command_in_ready,
    input  credit_pkg::command_buffer_line_t restart_command_in,
    input  logic                             restart_pending_in,
    input  credit_pkg::response_interface_t  response_in,
    output credit_pkg::command_buffer_line_t command_out,
    output logic [0:7]                       command_tag_out,
    output logic [0:7]                       credits_out,
    output logic                             restart_fifo_overflow
);
    localparam int TW = (TAG_COUNT > 1) ? $clog2(TAG_COUNT) : 1;
    localparam int FW = (RESTART_FIFO_DEPTH > 1) ? $clog2(RESTART_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(RESTART_FIFO_DEPTH + 1);

    logic                             enabled_q, enabled_d;
    logic [TAG_COUNT-1:0]             busy_q, busy_d;
    logic [TW-1:0]                    tag_ptr_q, tag_ptr_d;
    logic [7:0]                       credits_q, credits_d;
    credit_pkg::command_buffer_line_t command_out_q, command_out_d;
    logic                             overflow_q, overflow_d;
    logic [FW-1:0]                    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]                    count_q, count_d;
    credit_pkg::command_buffer_line_t fifo_mem [RESTART_FIFO_DEPTH];

    logic             fifo_empty, fifo_full, push, pop;
    logic             tag_free, can_issue, issue_wanted, issue_normal, issue;
    credit_pkg::command_t issue_cmd;

    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == CW'(RESTART_FIFO_DEPTH));
    assign push         = restart_command_in.valid && !fifo_full;
    assign tag_free     = ~busy_q[tag_ptr_q];
    assign can_issue    = (credits_q != 8'd0) && tag_free;
    assign pop          = enabled_q && !fifo_empty && can_issue;
    assign command_in_ready = enabled_q && !restart_pending_in && fifo_empty && can_issue;
    assign issue_normal = command_in.valid && command_in_ready;
    assign issue        = pop || issue_normal;
    // A busy tag under the pointer with work waiting makes the pointer scan forward.
    assign issue_wanted = enabled_q && (credits_q != 8'd0) &&
                          (!fifo_empty || (command_in.valid && !restart_pending_in));

    always_comb begin
        enabled_d     = enabled_in;
        busy_d        = busy_q;
        tag_ptr_d     = tag_ptr_q;
        credits_d     = credits_q;
        command_out_d = '0;
        overflow_d    = overflow_q | (restart_command_in.valid & fifo_full);
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q + CW'(push) - CW'(pop);

        issue_cmd     = pop ? fifo_mem[rd_ptr_q].cmd : command_in.cmd;
        issue_cmd.tag = 8'(tag_ptr_q);

        if (issue_wanted) begin
            tag_ptr_d = (tag_ptr_q == TW'(TAG_COUNT - 1)) ? '0 : tag_ptr_q + TW'(1);
        end

        if (response_in.valid) begin
            busy_d[response_in.tag[TW-1:0]] = 1'b0;
        end
        if (issue) begin
            busy_d[tag_ptr_q]   = 1'b1;
            command_out_d.valid = 1'b1;
            command_out_d.cmd   = issue_cmd;
        end

        if (issue && !response_in.valid) begin
            credits_d = credits_q - 8'd1;
        end else if (!issue && response_in.valid && credits_q != 8'(CREDITS_TOTAL)) begin
            credits_d = credits_q + 8'd1;
        end

        if (push) begin
            wr_ptr_d = (wr_ptr_q == FW'(RESTART_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + FW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == FW'(RESTART_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + FW'(1);
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            enabled_q     <= 1'b0;
            busy_q        <= '0;
            tag_ptr_q     <= '0;
            credits_q     <= 8'(CREDITS_TOTAL);
            command_out_q <= '0;
            overflow_q    <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            enabled_q     <= enabled_d;
            busy_q        <= busy_d;
            tag_ptr_q     <= tag_ptr_d;
            credits_q     <= credits_d;
            command_out_q <= command_out_d;
            overflow_q    <= overflow_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage only; occupancy lives in count_q so stale entries are never read.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= restart_command_in;
        end
    end

    assign command_out           = command_out_q;
    assign command_tag_out       = command_out_q.cmd.tag;
    assign credits_out           = credits_q;
    assign restart_fifo_overflow = overflow_q;
endmodule

// File: tb/tb_command_issue_control.sv
// tb/tb_command_issue_control.sv - directed self-checking bench for command_issue_control
module tb_command_issue_control;
    import credit_pkg::*;

    localparam int CT = credit_pkg::CREDITS_TOTAL;

    logic                 clock = 1'b0;
    logic                 rstn;
    logic                 enabled_in;
    command_buffer_line_t command_in;
    logic                 command_in_ready;
    command_buffer_line_t restart_command_in;
    logic                 restart_pending_in;
    response_interface_t  response_in;
    command_buffer_line_t command_out;
    logic [0:7]           command_tag_out;
    logic [0:7]           credits_out;
    logic                 restart_fifo_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    command_issue_control dut (
        .clock                 (clock),
        .rstn                  (rstn),
        .enabled_in            (enabled_in),
        .command_in            (command_in),
        .command_in_ready      (command_in_ready),
        .restart_command_in    (restart_command_in),
        .restart_pending_in    (restart_pending_in),
        .response_in           (response_in),
        .command_out           (command_out),
        .command_tag_out       (command_tag_out),
        .credits_out           (credits_out),
        .restart_fifo_overflow (restart_fifo_overflow)
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic command_buffer_line_t mk(input logic [7:0] op, input logic [2:0] abt);
        command_buffer_line_t c;
        c             = '0;
        c.valid       = 1'b1;
        c.cmd.opcode  = op;
        c.cmd.abt     = abt;
        c.cmd.address = {24'h0, op};
        return c;
    endfunction

    task automatic respond(input logic [7:0] t);
        response_in.valid = 1'b1;
        response_in.tag   = t;
        step();
        response_in = '0;
    endtask

    initial begin
        rstn               = 1'b0;
        enabled_in         = 1'b0;
        command_in         = '0;
        restart_command_in = '0;
        restart_pending_in = 1'b0;
        response_in        = '0;
        #12;
        check_eq("reset_valid", 64'(command_out.valid), 64'd0);
        check_eq("reset_tag", 64'(command_tag_out), 64'd0);
        check_eq("reset_credits", 64'(credits_out), 64'(CT));
        check_eq("reset_overflow", 64'(restart_fifo_overflow), 64'd0);
        @(negedge clock);
        rstn       = 1'b1;
        enabled_in = 1'b1;
        step();

        // back-to-back normal issue, then drain all credits
        for (int i = 0; i < CT; i++) begin
            command_in = mk(8'(8'h10 + i), 3'd0);
            step();
            if (i < 3) begin
                check_eq("b2b_valid", 64'(command_out.valid), 64'd1);
                check_eq("b2b_opcode", 64'(command_out.cmd.opcode), 64'(8'h10 + i));
                check_eq("b2b_credits", 64'(credits_out), 64'(CT - 1 - i));
            end
            check_eq("b2b_tag", 64'(command_tag_out), 64'(i));
        end
        check_eq("drain_credits", 64'(credits_out), 64'd0);
        #1;
        check_eq("drain_ready", 64'(command_in_ready), 64'd0);
        step();
        check_eq("drain_no_issue", 64'(command_out.valid), 64'd0);
        respond(8'd5);
        check_eq("resp_credit", 64'(credits_out), 64'd1);
        #1;
        check_eq("resp_ready", 64'(command_in_ready), 64'd1);
        step();
        check_eq("resp_issue_valid", 64'(command_out.valid), 64'd1);
        check_eq("resp_issue_tag", 64'(command_tag_out), 64'(CT));
        check_eq("resp_issue_cmdtag", 64'(command_out.cmd.tag), 64'(CT));
        check_eq("resp_issue_credits", 64'(credits_out), 64'd0);
        command_in = '0;

        // simultaneous issue and response keeps credits
        respond(8'd0);
        command_in        = mk(8'h30, 3'd0);
        response_in.valid = 1'b1;
        response_in.tag   = 8'd1;
        step();
        command_in  = '0;
        response_in = '0;
        check_eq("simul_tag", 64'(command_tag_out), 64'(CT + 1));
        check_eq("simul_credits", 64'(credits_out), 64'd1);
        for (int t = 2; t <= CT + 1; t++) begin
            if (t != 5) respond(8'(t));
        end
        check_eq("refill_credits", 64'(credits_out), 64'(CT));
        respond(8'd200);
        check_eq("credit_saturate", 64'(credits_out), 64'(CT));

        // restart priority
        restart_pending_in = 1'b1;
        command_in         = mk(8'h40, 3'd0);
        restart_command_in = mk(8'h50, 3'd1);
        #1;
        check_eq("rst_ready0", 64'(command_in_ready), 64'd0);
        step();
        restart_command_in = mk(8'h51, 3'd1);
        check_eq("rst_wait", 64'(command_out.valid), 64'd0);
        #1;
        check_eq("rst_ready1", 64'(command_in_ready), 64'd0);
        step();
        restart_command_in = '0;
        check_eq("rst1_opcode", 64'(command_out.cmd.opcode), 64'h50);
        check_eq("rst1_abt", 64'(command_out.cmd.abt), 64'd1);
        check_eq("rst1_tag", 64'(command_tag_out), 64'(CT + 2));
        #1;
        check_eq("rst_ready2", 64'(command_in_ready), 64'd0);
        step();
        check_eq("rst2_opcode", 64'(command_out.cmd.opcode), 64'h51);
        check_eq("rst2_tag", 64'(command_tag_out), 64'(CT + 3));
        #1;
        check_eq("rst_ready3", 64'(command_in_ready), 64'd0);
        step();
        check_eq("rst_idle", 64'(command_out.valid), 64'd0);
        restart_pending_in = 1'b0;
        #1;
        check_eq("rst_release_ready", 64'(command_in_ready), 64'd1);
        step();
        command_in = '0;
        check_eq("normal_after_opcode", 64'(command_out.cmd.opcode), 64'h40);
        check_eq("normal_after_tag", 64'(command_tag_out), 64'(CT + 4));
        check_eq("normal_after_credits", 64'(credits_out), 64'(CT - 3));
        respond(8'(CT + 2));
        respond(8'(CT + 3));
        respond(8'(CT + 4));

        // tag pointer wraps onto a busy tag 0
        for (int k = CT + 5; k < 512; k++) begin
            command_in = mk(8'h60, 3'd0);
            step();
            command_in = '0;
            if (k == CT + 5 || k == 255 || k == 256 || k == 511)
                check_eq("wrap_tag", 64'(command_tag_out), 64'(k % 256));
            if (k % 256 != 0) respond(8'(k % 256));
            else step();
        end
        command_in = mk(8'h70, 3'd0);
        step();
        check_eq("wrap_stall", 64'(command_out.valid), 64'd0);
        step();
        command_in = '0;
        check_eq("wrap_issue_valid", 64'(command_out.valid), 64'd1);
        check_eq("wrap_issue_tag", 64'(command_tag_out), 64'd1);
        respond(8'd0);
        respond(8'd1);
        check_eq("wrap_credits", 64'(credits_out), 64'(CT));

        // overflow with credits exhausted, then async reset mid-burst
        command_in = mk(8'h80, 3'd0);
        for (int i = 0; i < CT; i++) step();
        command_in = '0;
        check_eq("ovf_credits0", 64'(credits_out), 64'd0);
        for (int i = 0; i <= CT; i++) begin
            restart_command_in = mk(8'(8'h90 + i), 3'd1);
            step();
            if (i == CT - 1) check_eq("ovf_full_ok", 64'(restart_fifo_overflow), 64'd0);
        end
        restart_command_in = '0;
        check_eq("ovf_set", 64'(restart_fifo_overflow), 64'd1);
        step();
        step();
        check_eq("ovf_sticky", 64'(restart_fifo_overflow), 64'd1);
        respond(8'd2);
        step();
        check_eq("burst_valid", 64'(command_out.valid), 64'd1);
        check_eq("burst_opcode", 64'(command_out.cmd.opcode), 64'h90);
        check_eq("burst_tag", 64'(command_tag_out), 64'(CT + 2));
        rstn = 1'b0;
        #1;
        check_eq("async_valid", 64'(command_out.valid), 64'd0);
        check_eq("async_credits", 64'(credits_out), 64'(CT));
        check_eq("async_overflow", 64'(restart_fifo_overflow), 64'd0);
        step();
        rstn = 1'b1;
        step();
        step();
        step();
        check_eq("post_reset_idle", 64'(command_out.valid), 64'd0);
        check_eq("post_reset_credits", 64'(credits_out), 64'(CT));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
